core_branch_unit: RTL and testbench
===================================

Name: core_branch_unit

Overview:
Parametrised branch/jump execution unit for the core pipeline. Resolves direct and indirect branches under an 8-way condition set and emits a one-cycle redirect pulse with the target halfword pointer. Link (return-address) results are buffered in a WB_DEPTH-deep writeback queue so that writeback back-pressure does not stall branch resolution. Exports a RAW hazard mask covering every pending link destination. Sits beside the ALU, between issue and the writeback arbiter.

Parameters:
XLEN, 32, data word width; target/pc width is XLEN-1 (halfword pointer)
OFFSET_W, 12, width of signed direct-branch offset in halfwords, must be < XLEN-1
NREGS, 16, architectural register count; RD_W = clog2(NREGS)
WB_DEPTH, 4, link writeback queue depth, >= 1
RESET_PC, 0, byte address of reset vector, must be even

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  issue presents a branch op
in_ready  out  1  unit accepts op this cycle
in_pc  in  XLEN-1  halfword pc of branch insn
in_cond  in  3  condition code
in_indirect  in  1  1: target from a, 0: pc-relative
in_offset  in  OFFSET_W  signed halfword offset
in_link  in  1  write return address to in_rd
in_rd  in  RD_W  link destination register
a  in  XLEN  operand A (also indirect target)
b  in  XLEN  operand B
branch  out  1  redirect pulse
target  out  XLEN-1  redirect halfword pointer
wb_valid  out  1  link result available
wb_ready  in  1  writeback accepts result
wb_rd  out  RD_W  link destination
wb_value  out  XLEN  link byte address
raw_mask  out  NREGS  one bit per register with pending link write

Behaviour:
- Clock clk; reset rst synchronous, active-high.
- Accept = in_valid && in_ready. in_ready = !branch && (count < WB_DEPTH), count = queue occupancy; independent of in_link.
- Conditions (a, b): 0 ALWAYS, 1 EQ, 2 NE, 3 LT signed, 4 GE signed, 5 LTU, 6 GEU, 7 NEVER.
- Latency 1: on accept, branch <= taken at next edge; when taken, target <= in_indirect ? a[XLEN-1:1] : in_pc + sext(in_offset), modulo 2^(XLEN-1). Not-taken or no accept: branch <= 0, target holds.
- branch is high for exactly one cycle per taken branch; in_ready is low during it (wrong-path ops are never accepted).
- Link value = {in_pc + 2, 1'b0} truncated to XLEN; written whether or not branch is taken.
- Queue: on accept with in_link, push {in_rd, link value} at the edge. wb_valid = queue non-empty; head drives wb_rd/wb_value. Pop on wb_valid && wb_ready.
- Push and pop in the same cycle leave count unchanged. Push is never attempted while full, because in_ready gates it. Pointers wrap modulo WB_DEPTH. Outputs stay stable while wb_valid && !wb_ready.
- raw_mask = OR of onehot(rd) over all queue entries, OR onehot(in_rd) when accept && in_link (combinational). Duplicate rds are allowed. A bit clears only when no remaining entry names that register.
- Reset (any cycle, including mid-operation): queue emptied, wb_valid = 0, raw_mask = 0 (barring same-cycle combinational term), branch = 1, target = RESET_PC[XLEN-1:1].
- branch remains 1 until the first clk edge with rst low, then follows normal rules. in_ready is therefore 0 in that first post-reset cycle.

Test Plan:
- Reset release, RESET_PC=0x100 -> branch=1, target=0x80 during reset and first cycle after; then branch=0, in_ready=1, wb_valid=0, raw_mask=0.
- Direct BEQ, in_pc=0x40, offset=-4 (12'hFFC), a=b=5 -> next cycle branch=1, target=0x3C. Following cycle branch=0 and in_ready=1; op presented during the pulse is not accepted.
- Indirect ALWAYS with link, a=0x2001, in_rd=3, in_pc=0x10 -> target=0x1000; wb_valid=1, wb_rd=3, wb_value=0x24. raw_mask bit3 set the same cycle as accept and cleared after pop.
- Signed/unsigned split, a=0xFFFFFFFF, b=1: LT taken, LTU not taken (target holds), GE not taken, GEU taken; NEVER never pulses.
- wb_ready=0, issue 5 not-taken link ops (rd 1..5) with WB_DEPTH=4 -> in_ready drops after 4th, raw_mask=0x1E. Raise wb_ready: FIFO order rd 1,2,3,4, 5th accepted once a slot frees, simultaneous push/pop keeps count.
- Direct target wrap, in_pc=0x7FFFFFFF, offset=+2 -> target=0x00000001. Assert rst with 2 queued entries -> wb_valid=0 and raw_mask=0 next cycle.

Source files
------------

// File: rtl/core_branch_unit_if.sv
// Issue-side and writeback-side signal bundle for the branch unit.
interface core_branch_unit_if #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned OFFSET_W = 12,
   parameter int unsigned NREGS    = 16
);
   localparam int unsigned RD_W = (NREGS > 1) ? $clog2(NREGS) : 1;

   logic                in_valid;
   logic                in_ready;
   logic [XLEN-2:0]     in_pc;
   logic [2:0]          in_cond;
   logic                in_indirect;
   logic [OFFSET_W-1:0] in_offset;
   logic                in_link;
   logic [RD_W-1:0]     in_rd;
   logic [XLEN-1:0]     a;
   logic [XLEN-1:0]     b;
   logic                branch;
   logic [XLEN-2:0]     target;
   logic                wb_valid;
   logic                wb_ready;
   logic [RD_W-1:0]     wb_rd;
   logic [XLEN-1:0]     wb_value;
   logic [NREGS-1:0]    raw_mask;

   // Issue / writeback side
   modport master (
      output in_valid, in_pc, in_cond, in_indirect, in_offset, in_link, in_rd, a, b, wb_ready,
      input  in_ready, branch, target, wb_valid, wb_rd, wb_value, raw_mask
   );

   // Branch unit side
   modport slave (
      input  in_valid, in_pc, in_cond, in_indirect, in_offset, in_link, in_rd, a, b, wb_ready,
      output in_ready, branch, target, wb_valid, wb_rd, wb_value, raw_mask
   );
endinterface

// File: rtl/core_branch_unit.sv
// Branch/jump execution unit: resolves conditions, emits a one-cycle redirect
// pulse, and buffers link results in a small writeback queue.
module core_branch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     OFFSET_W = 12,
   parameter int unsigned     NREGS    = 16,
   parameter int unsigned     WB_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic               clk,
   input logic               rst,
   core_branch_unit_if.slave bus
);
   localparam int unsigned RD_W  = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam int unsigned PC_W  = XLEN - 1;
   localparam int unsigned PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(WB_DEPTH + 1);
   localparam logic [CNT_W-1:0] CntFull = CNT_W'(WB_DEPTH);
   localparam logic [PTR_W-1:0] PtrLast = PTR_W'(WB_DEPTH - 1);

   logic                branch_q;
   logic [PC_W-1:0]     target_q;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q;
   logic [WB_DEPTH-1:0] valid_q;
   logic [RD_W-1:0]     rd_q  [WB_DEPTH];
   logic [XLEN-1:0]     val_q [WB_DEPTH];

   logic                accept, taken, push, pop;
   logic [PC_W-1:0]     offset_sext, target_d;
   logic [XLEN-1:0]     link_value;
   logic [NREGS-1:0]    raw_mask_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PtrLast) ? '0 : p + 1'b1;
   endfunction

   // Wrong-path ops are blocked while the redirect pulse is out.
   assign bus.in_ready = !branch_q && (count_q < CntFull);
   assign accept       = bus.in_valid && bus.in_ready;
   assign push         = accept && bus.in_link;
   assign pop          = (count_q != '0) && bus.wb_ready;

   assign offset_sext = {{(PC_W - OFFSET_W){bus.in_offset[OFFSET_W-1]}}, bus.in_offset};
   assign target_d    = bus.in_indirect ? bus.a[XLEN-1:1] : bus.in_pc + offset_sext;
   // Return address is the byte address of the next 32-bit instruction.
   assign link_value  = {bus.in_pc + PC_W'(2), 1'b0};

   // Condition evaluation on operands a/b
   always_comb begin
      taken = 1'b0;
      unique case (bus.in_cond)
         3'd0:    taken = 1'b1;
         3'd1:    taken = (bus.a == bus.b);
         3'd2:    taken = (bus.a != bus.b);
         3'd3:    taken = ($signed(bus.a) < $signed(bus.b));
         3'd4:    taken = ($signed(bus.a) >= $signed(bus.b));
         3'd5:    taken = (bus.a < bus.b);
         3'd6:    taken = (bus.a >= bus.b);
         default: taken = 1'b0;
      endcase
   end

   // Hazard mask: every queued destination plus the one being pushed now
   always_comb begin
      raw_mask_d = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         if (valid_q[i]) raw_mask_d[rd_q[i]] = 1'b1;
      end
      if (push) raw_mask_d[bus.in_rd] = 1'b1;
   end

   // Redirect pulse and target; reset behaves as a redirect to the reset vector
   always_ff @(posedge clk) begin
      if (rst) begin
         branch_q <= 1'b1;
         target_q <= RESET_PC[XLEN-1:1];
      end else begin
         branch_q <= accept && taken;
         if (accept && taken) target_q <= target_d;
      end
   end

   // Queue pointers, occupancy and per-slot valid bits
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         if (push) begin
            valid_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q          <= ptr_inc(wr_ptr_q);
         end
         // Push and pop never target the same slot: that needs empty and full at once.
         if (pop) begin
            valid_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q          <= ptr_inc(rd_ptr_q);
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Queue payload storage, qualified by valid_q so no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         rd_q[wr_ptr_q]  <= bus.in_rd;
         val_q[wr_ptr_q] <= link_value;
      end
   end

   assign bus.branch   = branch_q;
   assign bus.target   = target_q;
   assign bus.wb_valid = (count_q != '0);
   assign bus.wb_rd    = rd_q[rd_ptr_q];
   assign bus.wb_value = val_q[rd_ptr_q];
   assign bus.raw_mask = raw_mask_d;
endmodule

// File: tb/tb_core_branch_unit.sv
// Directed bench for core_branch_unit with a link-writeback scoreboard.
module tb_core_branch_unit;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   core_branch_unit_if #(.XLEN(32), .OFFSET_W(12), .NREGS(16)) bus ();

   core_branch_unit #(
      .XLEN(32), .OFFSET_W(12), .NREGS(16), .WB_DEPTH(4), .RESET_PC(32'h100)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [3:0]  rd;
      logic [31:0] val;
   } wb_exp_t;

   wb_exp_t exp_q[$];
   wb_exp_t mon_e;
   int      n_checks = 0;
   int      n_pass   = 0;
   int      n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [30:0] pc, input logic [2:0] cond, input logic ind,
                        input logic [11:0] off, input logic link, input logic [3:0] rd,
                        input logic [31:0] av, input logic [31:0] bv);
      bus.in_valid    = 1'b1;
      bus.in_pc       = pc;
      bus.in_cond     = cond;
      bus.in_indirect = ind;
      bus.in_offset   = off;
      bus.in_link     = link;
      bus.in_rd       = rd;
      bus.a           = av;
      bus.b           = bv;
   endtask

   // Hold the driven op until accepted; record expected link writeback on accept.
   task automatic accept_op();
      bit done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         if (bus.in_ready) begin
            if (bus.in_link)
               exp_q.push_back('{rd: bus.in_rd,
                                 val: 32'(({1'b0, bus.in_pc} << 1) + 33'd4)});
            done = 1'b1;
         end
         tick();
      end
      bus.in_valid = 1'b0;
      if (!done) check("accept_timeout", bus.in_ready, 1'b1);
   endtask

   // Scoreboard: compare the queue head whenever a pop is about to happen.
   always @(negedge clk) begin
      if (!rst && bus.wb_valid && bus.wb_ready) begin
         if (exp_q.size() == 0) begin
            check("wb_unexpected", bus.wb_valid, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            check("wb_rd", bus.wb_rd, mon_e.rd);
            check("wb_value", bus.wb_value, mon_e.val);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus.wb_ready = 1'b1;
      drive(31'h0, 3'd7, 1'b0, 12'h0, 1'b0, 4'd0, 32'h0, 32'h0);
      bus.in_valid = 1'b0;
      repeat (2) tick();
      check("rst_branch", bus.branch, 1'b1);
      check("rst_target", bus.target, 31'h80);
      check("rst_wb_valid", bus.wb_valid, 1'b0);
      check("rst_raw_mask", bus.raw_mask, 16'h0);
      rst = 1'b0;
      #1;
      check("post_rst_branch", bus.branch, 1'b1);
      check("post_rst_ready", bus.in_ready, 1'b0);
      tick();
      check("idle_branch", bus.branch, 1'b0);
      check("idle_ready", bus.in_ready, 1'b1);
      check("idle_wb_valid", bus.wb_valid, 1'b0);
      check("idle_raw_mask", bus.raw_mask, 16'h0);

      // Direct BEQ, backwards offset
      drive(31'h40, 3'd1, 1'b0, 12'hFFC, 1'b0, 4'd0, 32'd5, 32'd5);
      accept_op();
      check("beq_branch", bus.branch, 1'b1);
      check("beq_target", bus.target, 31'h3C);
      check("beq_pulse_ready", bus.in_ready, 1'b0);
      drive(31'h200, 3'd0, 1'b0, 12'h010, 1'b0, 4'd0, 32'h0, 32'h0);
      #1;
      check("wrong_path_ready", bus.in_ready, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      check("wrong_path_branch", bus.branch, 1'b0);
      check("wrong_path_target", bus.target, 31'h3C);
      check("after_pulse_ready", bus.in_ready, 1'b1);

      // Indirect jump with link
      bus.wb_ready = 1'b0;
      drive(31'h10, 3'd0, 1'b1, 12'h0, 1'b1, 4'd3, 32'h2001, 32'h0);
      #1;
      check("jal_raw_same_cycle", bus.raw_mask, 16'h0008);
      accept_op();
      check("jal_branch", bus.branch, 1'b1);
      check("jal_target", bus.target, 31'h1000);
      check("jal_wb_valid", bus.wb_valid, 1'b1);
      check("jal_wb_rd", bus.wb_rd, 4'd3);
      check("jal_wb_value", bus.wb_value, 32'h24);
      check("jal_raw_mask", bus.raw_mask, 16'h0008);
      tick();
      check("jal_pulse_end", bus.branch, 1'b0);
      check("jal_wb_stable", bus.wb_value, 32'h24);
      bus.wb_ready = 1'b1;
      tick();
      check("jal_popped_valid", bus.wb_valid, 1'b0);
      check("jal_popped_mask", bus.raw_mask, 16'h0);

      // Signed vs unsigned conditions, a = -1, b = 1
      drive(31'h100, 3'd3, 1'b0, 12'h020, 1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1);
      accept_op();
      check("lt_branch", bus.branch, 1'b1);
      check("lt_target", bus.target, 31'h120);
      drive(31'h300, 3'd5, 1'b0, 12'h000, 1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1);
      accept_op();
      check("ltu_branch", bus.branch, 1'b0);
      check("ltu_target_hold", bus.target, 31'h120);
      drive(31'h300, 3'd4, 1'b0, 12'h000, 1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1);
      accept_op();
      check("ge_branch", bus.branch, 1'b0);
      check("ge_target_hold", bus.target, 31'h120);
      drive(31'h200, 3'd6, 1'b0, 12'h004, 1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1);
      accept_op();
      check("geu_branch", bus.branch, 1'b1);
      check("geu_target", bus.target, 31'h204);
      drive(31'h500, 3'd7, 1'b0, 12'h000, 1'b0, 4'd0, 32'd9, 32'd9);
      accept_op();
      check("never_branch", bus.branch, 1'b0);
      check("never_target_hold", bus.target, 31'h204);
      tick();
      check("never_branch_late", bus.branch, 1'b0);

      // Fill the queue under back-pressure
      bus.wb_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(31'(32'h1000 + i * 8), 3'd7, 1'b0, 12'h0, 1'b1, 4'(i), 32'h0, 32'h0);
         accept_op();
      end
      check("full_ready", bus.in_ready, 1'b0);
      check("full_raw_mask", bus.raw_mask, 16'h001E);
      check("full_wb_valid", bus.wb_valid, 1'b1);
      check("full_head_rd", bus.wb_rd, 4'd1);
      check("full_head_value", bus.wb_value, 32'h2014);
      drive(31'h1028, 3'd7, 1'b0, 12'h0, 1'b1, 4'd5, 32'h0, 32'h0);
      #1;
      check("fifth_blocked", bus.in_ready, 1'b0);
      tick();
      tick();
      check("fifth_not_pushed", bus.raw_mask, 16'h001E);
      bus.wb_ready = 1'b1;
      accept_op();
      bus.wb_ready = 1'b0;
      check("pushpop_mask", bus.raw_mask, 16'h0038);
      check("pushpop_head", bus.wb_rd, 4'd3);
      drive(31'h1030, 3'd7, 1'b0, 12'h0, 1'b1, 4'd6, 32'h0, 32'h0);
      accept_op();
      check("refill_ready", bus.in_ready, 1'b0);
      check("refill_mask", bus.raw_mask, 16'h0078);
      bus.wb_ready = 1'b1;
      for (int i = 0; i < 20 && bus.wb_valid; i++) tick();
      check("drain_wb_valid", bus.wb_valid, 1'b0);
      check("drain_raw_mask", bus.raw_mask, 16'h0);
      check("sb_empty", exp_q.size(), 0);

      // Target wrap, then reset with two entries pending
      bus.wb_ready = 1'b0;
      drive(31'h7FFF_FFFF, 3'd0, 1'b0, 12'h002, 1'b1, 4'd7, 32'h0, 32'h0);
      accept_op();
      check("wrap_branch", bus.branch, 1'b1);
      check("wrap_target", bus.target, 31'h1);
      check("wrap_link_value", bus.wb_value, 32'h2);
      drive(31'h20, 3'd7, 1'b0, 12'h0, 1'b1, 4'd9, 32'h0, 32'h0);
      accept_op();
      check("pre_rst_mask", bus.raw_mask, 16'h0280);
      check("pre_rst_wb_valid", bus.wb_valid, 1'b1);
      rst = 1'b1;
      exp_q.delete();
      tick();
      check("mid_rst_wb_valid", bus.wb_valid, 1'b0);
      check("mid_rst_raw_mask", bus.raw_mask, 16'h0);
      check("mid_rst_branch", bus.branch, 1'b1);
      check("mid_rst_target", bus.target, 31'h80);
      rst = 1'b0;
      tick();
      check("rerun_branch", bus.branch, 1'b0);
      check("rerun_ready", bus.in_ready, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
